hall_position_tracker: RTL and testbench

Converts the three raw motor Hall sensor lines into a debounced commutation sector, a signed 24-bit step position and a windowed step-rate velocity. Sits directly upstream of the PID/commutation block: `position` drives its `state` input, and the debounced Hall bits feed its commutation inputs. Illegal or skipped Hall transitions are flagged and never counted.

---
 rtl/motor_pkg.sv | 47 ++++
 rtl/hall_debounce.sv | 61 ++++++
 rtl/hall_position_tracker.sv | 151 +++++++++++++++
 tb/tb_hall_position_tracker.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// Shared motor-control types and helpers: widths, sector lookup,
// tracker state encoding and saturating position arithmetic.
package motor_pkg;

    localparam int unsigned POS_WIDTH = 24;

    localparam logic [2:0] SECTOR_UNKNOWN = 3'd7;

    localparam logic signed [POS_WIDTH-1:0] POS_MAX = {1'b0, {(POS_WIDTH-1){1'b1}}};
    localparam logic signed [POS_WIDTH-1:0] POS_MIN = {1'b1, {(POS_WIDTH-1){1'b0}}};

    // Tracker state encoding
    localparam logic [0:0] ST_UNSEEDED = 1'b0;
    localparam logic [0:0] ST_TRACKING = 1'b1;

    // Map a {hall1,hall2,hall3} code onto its commutation sector
    function automatic logic [2:0] hall_to_sector(input logic [2:0] code);
        logic [2:0] result;
        case (code)
            3'b101:  result = 3'd0;
            3'b100:  result = 3'd1;
            3'b110:  result = 3'd2;
            3'b010:  result = 3'd3;
            3'b011:  result = 3'd4;
            3'b001:  result = 3'd5;
            default: result = SECTOR_UNKNOWN;
        endcase
        return result;
    endfunction

    // Apply a +1/-1 step that sticks at the signed range limits
    function automatic logic signed [POS_WIDTH-1:0] sat_step(
        input logic signed [POS_WIDTH-1:0] value,
        input logic                        up,
        input logic                        down
    );
        logic signed [POS_WIDTH-1:0] result;
        result = value;
        if (up && (value != POS_MAX)) begin
            result = value + POS_WIDTH'(1);
        end else if (down && (value != POS_MIN)) begin
            result = value - POS_WIDTH'(1);
        end
        return result;
    endfunction

endpackage

// File: rtl/hall_debounce.sv
// Two-flop synchronizer plus run-length debounce for the three Hall lines.
// `changed` pulses for one cycle whenever hall_db takes a new value.
module hall_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] raw,
    output logic [2:0] hall_db,
    output logic       changed
);

    localparam int unsigned CNT_W = 8;

    logic [2:0]       sync1;
    logic [2:0]       sync2;
    logic [2:0]       cand;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] run_len;

    // Synchronize the asynchronous Hall lines into the clock domain
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 3'b000;
            sync2 <= 3'b000;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Length of the current run of identical samples, including this one
    always_comb begin
        if (sync2 != cand) begin
            run_len = CNT_W'(1);
        end else if (cnt >= CNT_W'(DEBOUNCE_CYCLES)) begin
            run_len = cnt;
        end else begin
            run_len = cnt + CNT_W'(1);
        end
    end

    // Accept the candidate once it has been stable long enough
    always_ff @(posedge clk) begin
        if (reset) begin
            cand    <= 3'b000;
            cnt     <= '0;
            hall_db <= 3'b000;
            changed <= 1'b0;
        end else begin
            cand    <= sync2;
            cnt     <= run_len;
            changed <= 1'b0;
            if ((run_len == CNT_W'(DEBOUNCE_CYCLES)) && (sync2 != hall_db)) begin
                hall_db <= sync2;
                changed <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/hall_position_tracker.sv
// Hall sensor front end: debounced sector, saturating step position and
// optional windowed velocity. Build with HALL_VELOCITY_EN defined to include
// the velocity window; otherwise velocity/velocity_valid are tied to 0.
module hall_position_tracker
    import motor_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned VEL_WINDOW      = 65536
) (
    input  logic                        CLK,
    input  logic                        reset,
    input  logic                        hall1,
    input  logic                        hall2,
    input  logic                        hall3,
    input  logic                        zero_position,
    output logic [2:0]                  hall_db,
    output logic [2:0]                  sector,
    output logic signed [POS_WIDTH-1:0] position,
    output logic                        direction,
    output logic                        step_pulse,
    output logic                        hall_error,
    output logic signed [POS_WIDTH-1:0] velocity,
    output logic                        velocity_valid
);

    logic                        db_changed;
    logic [0:0]                  state;
    logic [0:0]                  state_next;
    logic [2:0]                  sector_next;
    logic [2:0]                  new_sector;
    logic [3:0]                  diff;
    logic [2:0]                  delta;
    logic                        step_up;
    logic                        step_down;
    logic                        direction_next;
    logic                        error_next;
    logic signed [POS_WIDTH-1:0] position_next;

    hall_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (CLK),
        .reset  (reset),
        .raw    ({hall1, hall2, hall3}),
        .hall_db(hall_db),
        .changed(db_changed)
    );

    // Tracker next-state: classify each debounced change as seed, step or error
    always_comb begin
        state_next     = state;
        sector_next    = sector;
        direction_next = direction;
        step_up        = 1'b0;
        step_down      = 1'b0;
        error_next     = 1'b0;
        new_sector     = hall_to_sector(hall_db);
        diff           = 4'(new_sector) + 4'd6 - 4'(sector);
        delta          = (diff >= 4'd6) ? 3'(diff - 4'd6) : 3'(diff);

        if (db_changed) begin
            if (new_sector == SECTOR_UNKNOWN) begin
                error_next = 1'b1;
            end else if (state == ST_UNSEEDED) begin
                sector_next = new_sector;
                state_next  = ST_TRACKING;
            end else begin
                sector_next = new_sector;
                case (delta)
                    3'd1: begin
                        step_up        = 1'b1;
                        direction_next = 1'b1;
                    end
                    3'd5: begin
                        step_down      = 1'b1;
                        direction_next = 1'b0;
                    end
                    3'd2, 3'd3, 3'd4: error_next = 1'b1;
                    default: ;
                endcase
            end
        end

        if (zero_position) begin
            position_next = '0;
        end else begin
            position_next = sat_step(position, step_up, step_down);
        end
    end

    // Tracker state and registered outputs
    always_ff @(posedge CLK) begin
        if (reset) begin
            state      <= ST_UNSEEDED;
            sector     <= SECTOR_UNKNOWN;
            position   <= '0;
            direction  <= 1'b0;
            step_pulse <= 1'b0;
            hall_error <= 1'b0;
        end else begin
            state      <= state_next;
            sector     <= sector_next;
            position   <= position_next;
            direction  <= direction_next;
            step_pulse <= step_up | step_down;
            hall_error <= error_next;
        end
    end

`ifdef HALL_VELOCITY_EN
    localparam int unsigned WIN_W = (VEL_WINDOW > 2) ? $clog2(VEL_WINDOW) : 1;

    logic [WIN_W-1:0]            win_cnt;
    logic signed [POS_WIDTH-1:0] vel_acc;
    logic signed [POS_WIDTH-1:0] vel_acc_next;

    // Accumulator including this cycle's step
    always_comb begin
        vel_acc_next = sat_step(vel_acc, step_up, step_down);
    end

    // Free-running window: publish and clear the accumulator on the last cycle
    always_ff @(posedge CLK) begin
        if (reset) begin
            win_cnt        <= '0;
            vel_acc        <= '0;
            velocity       <= '0;
            velocity_valid <= 1'b0;
        end else begin
            velocity_valid <= 1'b0;
            if (win_cnt == WIN_W'(VEL_WINDOW - 1)) begin
                win_cnt        <= '0;
                vel_acc        <= '0;
                velocity       <= vel_acc_next;
                velocity_valid <= 1'b1;
            end else begin
                win_cnt <= win_cnt + WIN_W'(1);
                vel_acc <= vel_acc_next;
            end
        end
    end
`else
    logic unused_vel_cfg;

    // Velocity measurement not built
    assign velocity       = '0;
    assign velocity_valid = 1'b0;
    assign unused_vel_cfg = ^(32'(VEL_WINDOW));
`endif

endmodule

// File: tb/tb_hall_position_tracker.sv
// Self-checking bench for hall_position_tracker: directed scenarios with
// literal expectations plus randomized Hall traffic against a cycle model.
module tb_hall_position_tracker;

    localparam int unsigned D = 4;
    localparam int unsigned W = 100;
    localparam int PMAX = 8388607;
    localparam int PMIN = -8388608;

`ifdef HALL_VELOCITY_EN
    localparam bit VEL_EN = 1'b1;
`else
    localparam bit VEL_EN = 1'b0;
`endif

    logic               CLK;
    logic               reset;
    logic               hall1, hall2, hall3;
    logic               zero_position;
    logic [2:0]         hall_db;
    logic [2:0]         sector;
    logic signed [23:0] position;
    logic               direction;
    logic               step_pulse;
    logic               hall_error;
    logic signed [23:0] velocity;
    logic               velocity_valid;

    int vectors     = 0;
    int miscompares = 0;
    int n_steps     = 0;
    int n_errs      = 0;
    int n_valid     = 0;
    bit force_req   = 1'b0;

    // sector of each 3-bit code (7 = invalid), and code of each sector
    int sector_of [8] = '{7, 5, 3, 4, 1, 0, 2, 7};
    int code_of   [6] = '{5, 4, 6, 2, 3, 1};

    hall_position_tracker #(
        .DEBOUNCE_CYCLES(D),
        .VEL_WINDOW     (W)
    ) dut (
        .CLK           (CLK),
        .reset         (reset),
        .hall1         (hall1),
        .hall2         (hall2),
        .hall3         (hall3),
        .zero_position (zero_position),
        .hall_db       (hall_db),
        .sector        (sector),
        .position      (position),
        .direction     (direction),
        .step_pulse    (step_pulse),
        .hall_error    (hall_error),
        .velocity      (velocity),
        .velocity_valid(velocity_valid)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clamp24(input int v);
        if (v > PMAX) return PMAX;
        if (v < PMIN) return PMIN;
        return v;
    endfunction

    // ---------------- behavioural model ----------------
    int m_s1, m_s2, m_cand, m_run, m_db, m_chg;
    int m_sec, m_seeded, m_pos, m_dir, m_step, m_err;
    int m_vcnt, m_vacc, m_vel, m_vvalid;

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_cand = 0; m_run = 0; m_db = 0; m_chg = 0;
        m_sec = 7; m_seeded = 0; m_pos = 0; m_dir = 0; m_step = 0; m_err = 0;
        m_vcnt = 0; m_vacc = 0; m_vel = 0; m_vvalid = 0;
    endtask

    initial begin
        int raw, step, ns, d;
        model_reset();
        forever begin
            @(posedge CLK);
            raw = int'({hall1, hall2, hall3});
            if (reset) begin
                model_reset();
            end else begin
                // position tracker acts on the previous cycle's debounced change
                step  = 0;
                m_err = 0;
                if (m_chg != 0) begin
                    ns = sector_of[m_db];
                    if (ns == 7) begin
                        m_err = 1;
                    end else if (m_seeded == 0) begin
                        m_sec    = ns;
                        m_seeded = 1;
                    end else begin
                        d = (ns - m_sec + 6) % 6;
                        if (d == 1) step = 1;
                        else if (d == 5) step = -1;
                        else if (d != 0) m_err = 1;
                        if (step != 0) m_dir = (step > 0) ? 1 : 0;
                        m_sec = ns;
                    end
                end
                m_step = (step != 0) ? 1 : 0;
                m_pos  = zero_position ? 0 : clamp24(m_pos + step);
                if (force_req) m_pos = PMAX;
                // velocity window
                m_vacc   = clamp24(m_vacc + step);
                m_vvalid = 0;
                if (m_vcnt == int'(W) - 1) begin
                    m_vel    = m_vacc;
                    m_vacc   = 0;
                    m_vvalid = 1;
                    m_vcnt   = 0;
                end else begin
                    m_vcnt++;
                end
                // debounce: accept after D equal synchronized samples
                m_chg = 0;
                if (m_s2 == m_cand) begin
                    if (m_run < int'(D)) m_run++;
                end else begin
                    m_cand = m_s2;
                    m_run  = 1;
                end
                if (m_run == int'(D) && m_s2 != m_db) begin
                    m_db  = m_s2;
                    m_chg = 1;
                end
                m_s2 = m_s1;
                m_s1 = raw;
            end
        end
    end

    // Compare every cycle, away from the active edge
    initial begin
        forever begin
            @(negedge CLK);
            check("hall_db",        int'(hall_db),        m_db);
            check("sector",         int'(sector),         m_sec);
            check("position",       int'(position),       m_pos);
            check("direction",      int'(direction),      m_dir);
            check("step_pulse",     int'(step_pulse),     m_step);
            check("hall_error",     int'(hall_error),     m_err);
            check("velocity",       int'(velocity),       VEL_EN ? m_vel : 0);
            check("velocity_valid", int'(velocity_valid), VEL_EN ? m_vvalid : 0);
            if (step_pulse)     n_steps++;
            if (hall_error)     n_errs++;
            if (velocity_valid) n_valid++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic set_hall(input logic [2:0] c);
        {hall1, hall2, hall3} = c;
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        int s0, e0, cur, r, code, hold;
        logic [2:0] fwd [6];
        logic [2:0] rev [6];
        fwd = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};
        rev = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};

        reset = 1'b1;
        zero_position = 1'b0;
        set_hall(3'b000);
        tick(3);
        check("rst_sector",   int'(sector),   7);
        check("rst_position", int'(position), 0);
        check("rst_hall_db",  int'(hall_db),  0);

        // seed: first valid code appears as a sector D+3 cycles later
        reset = 1'b0;
        set_hall(3'b101);
        tick(6);
        check("seed_early_sector", int'(sector), 7);
        tick(1);
        check("seed_sector",   int'(sector),     0);
        check("seed_position", int'(position),   0);
        check("seed_step",     int'(step_pulse), 0);
        check("seed_error",    int'(hall_error), 0);

        // one forward revolution
        s0 = n_steps; e0 = n_errs;
        for (int i = 0; i < 6; i++) begin
            set_hall(fwd[i]);
            tick(20);
        end
        check("fwd_position",  int'(position),  6);
        check("fwd_direction", int'(direction), 1);
        check("fwd_steps",     n_steps - s0,    6);
        check("fwd_errors",    n_errs - e0,     0);

        // one reverse revolution
        s0 = n_steps;
        for (int i = 0; i < 6; i++) begin
            set_hall(rev[i]);
            tick(20);
        end
        check("rev_position",  int'(position),  0);
        check("rev_direction", int'(direction), 0);
        check("rev_steps",     n_steps - s0,    6);

        // short glitch is rejected
        s0 = n_steps; e0 = n_errs;
        set_hall(3'b100);
        tick(3);
        set_hall(3'b101);
        tick(20);
        check("glitch_hall_db", int'(hall_db), 5);
        check("glitch_steps",   n_steps - s0,  0);
        check("glitch_errors",  n_errs - e0,   0);

        // invalid code held, then back to the same sector
        set_hall(3'b111);
        tick(20);
        check("invalid_errors", n_errs - e0,   1);
        check("invalid_sector", int'(sector),  0);
        set_hall(3'b101);
        tick(20);
        check("return_errors", n_errs - e0,   1);
        check("return_steps",  n_steps - s0,  0);

        // skip of two sectors
        set_hall(3'b110);
        tick(20);
        check("skip_errors",   n_errs - e0,    2);
        check("skip_sector",   int'(sector),   2);
        check("skip_position", int'(position), 0);

        // saturation at the positive limit
        force dut.position = 24'sh7FFFFF;
        force_req = 1'b1;
        tick(1);
        release dut.position;
        force_req = 1'b0;
        s0 = n_steps;
        set_hall(3'b010);
        tick(20);
        check("sat_position",  int'(position),  PMAX);
        check("sat_steps",     n_steps - s0,    1);
        check("sat_direction", int'(direction), 1);

        // zero_position coincident with a step
        set_hall(3'b011);
        tick(6);
        zero_position = 1'b1;
        tick(1);
        zero_position = 1'b0;
        check("zero_position", int'(position),   0);
        check("zero_step",     int'(step_pulse), 1);
        tick(15);

        // velocity: three forward steps, then two reverse steps
        reset = 1'b1;
        set_hall(3'b101);
        tick(2);
        reset = 1'b0;
        s0 = n_valid;
        tick(20); set_hall(3'b100);
        tick(20); set_hall(3'b110);
        tick(20); set_hall(3'b010);
        tick(39);
        check("vel_early_valid", int'(velocity_valid), 0);
        tick(1);
        check("vel1_valid", int'(velocity_valid), VEL_EN ? 1 : 0);
        check("vel1_value", int'(velocity),       VEL_EN ? 3 : 0);
        tick(20); set_hall(3'b110);
        tick(20); set_hall(3'b100);
        tick(60);
        check("vel2_valid", int'(velocity_valid), VEL_EN ? 1 : 0);
        check("vel2_value", int'(velocity),       VEL_EN ? -2 : 0);
        check("vel_pulses", n_valid - s0,         VEL_EN ? 2 : 0);

        // reset in the middle of a debounce
        set_hall(3'b110);
        tick(5);
        reset = 1'b1;
        tick(1);
        check("mid_rst_sector",   int'(sector),         7);
        check("mid_rst_position", int'(position),       0);
        check("mid_rst_hall_db",  int'(hall_db),        0);
        check("mid_rst_dir",      int'(direction),      0);
        check("mid_rst_velocity", int'(velocity),       0);
        reset = 1'b0;
        s0 = n_steps; e0 = n_errs;
        tick(7);
        check("reseed_sector", int'(sector),   2);
        check("reseed_steps",  n_steps - s0,   0);
        check("reseed_errors", n_errs - e0,    0);
        check("reseed_pos",    int'(position), 0);

        // randomized Hall traffic against the model
        cur = 2;
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 11));
            if (r <= 4)      cur = (cur + 1) % 6;
            else if (r <= 7) cur = (cur + 5) % 6;
            else if (r == 8) cur = (cur + 2) % 6;
            code = code_of[cur];
            if (r == 9) code = int'($urandom_range(0, 7));
            set_hall(3'(code));
            hold = int'($urandom_range(1, 24));
            for (int k = 0; k < hold; k++) begin
                zero_position = ($urandom_range(0, 59) == 0);
                reset         = ($urandom_range(0, 399) == 0);
                tick(1);
            end
            zero_position = 1'b0;
            reset = 1'b0;
        end
        tick(30);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
